// File: rtl/waveform_playback_buffer_if.sv
// AXI-Stream style bundle used for both the waveform capture and playback ports.
interface waveform_playback_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/waveform_playback_buffer.sv
// Captures one waveform from a stream into BRAM and replays it on trigger,
// N times or continuously, at one word per clock through a 2-entry skid buffer.
module waveform_playback_buffer #(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 10,
  parameter bit WRITE_BEFORE_READ = 1'b1
) (
  input  logic         clk_in1,
  input  logic         rst,
  input  logic [127:0] waveform_parameters,
  input  logic         init_wf_write,
  input  logic         wf_trigger,
  input  logic         wf_stop,
  output logic         wf_write_ready,
  output logic         wf_read_ready,
  output logic         wf_len_err,
  waveform_playback_buffer_if.slave  wfin_axis,
  waveform_playback_buffer_if.master wfout_axis
);
  localparam int          LW      = ADDR_WIDTH + 1;
  localparam logic [31:0] MAX_LEN = 32'(2**ADDR_WIDTH);

  typedef enum logic [1:0] {IDLE, WRITE, ARMED, PLAY} state_t;
  state_t state, next_state;

  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];
  logic [31:0]           len_in, rep_in, rep_reg, rep_cnt, cur_rep;
  logic [LW-1:0]         len_reg, wr_count;
  logic [ADDR_WIDTH-1:0] rd_addr, play_last, start_last, cur_addr, cur_last;
  logic                  in_ready, init_seen, len_bad, init_ok, beat, overflow, capture_done;
  logic                  start, issue, issue_done, eor_c, fin_c;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid, rd_eor, rd_fin, push, pop, done, stall;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_eor, fifo_fin;
  logic                  wptr, rptr, out_valid, out_last;
  logic [1:0]            cnt;
  logic [2:0]            occ;
  logic                  stop_req, stop_vis;
  logic                  unused_bits;

  assign unused_bits  = ^{waveform_parameters[127:64], wfin_axis.tkeep};
  assign len_in       = waveform_parameters[31:0];
  assign rep_in       = waveform_parameters[63:32];
  assign init_seen    = init_wf_write && (state == IDLE || state == ARMED);
  assign len_bad      = (len_in == 32'd0) || (len_in > MAX_LEN);
  assign init_ok      = init_seen && !len_bad;
  assign beat         = wfin_axis.tvalid && in_ready;
  assign overflow     = (wr_count == len_reg);
  assign capture_done = beat && wfin_axis.tlast;
  assign wfin_axis.tready = in_ready;

  assign out_valid = (cnt != 2'd0);
  assign out_last  = fifo_fin[rptr] || (fifo_eor[rptr] && stop_vis);
  assign pop       = out_valid && wfout_axis.tready;
  assign done      = pop && out_last;
  assign stall     = out_valid && !wfout_axis.tready;
  assign push      = rd_valid && !done;

  assign wfout_axis.tvalid = out_valid;
  assign wfout_axis.tdata  = out_valid ? fifo_data[rptr] : '0;
  assign wfout_axis.tkeep  = out_valid ? '1 : '0;
  assign wfout_axis.tlast  = out_valid && out_last;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (init_ok) next_state = WRITE;
             else if (wf_trigger && !init_wf_write && !WRITE_BEFORE_READ) next_state = PLAY;
      WRITE: if (capture_done) next_state = ARMED;
      ARMED: if (init_ok) next_state = WRITE;
             else if (wf_trigger && !init_wf_write) next_state = PLAY;
      PLAY:  if (done) next_state = ARMED;
      default: next_state = IDLE;
    endcase
  end

  // A read is issued only when the word can land in the skid buffer, counting the one in flight.
  assign occ        = {1'b0, cnt} + {2'b00, rd_valid};
  assign start      = (state != PLAY) && (next_state == PLAY);
  assign start_last = ADDR_WIDTH'(len_reg - LW'(1));
  assign issue      = start || ((state == PLAY) && !issue_done && !done &&
                                ((occ < 3'd2) || ((occ == 3'd2) && pop)));
  assign cur_addr   = start ? '0 : rd_addr;
  assign cur_last   = start ? start_last : play_last;
  assign cur_rep    = start ? 32'd0 : rep_cnt;
  assign eor_c      = (cur_addr == cur_last);
  assign fin_c      = eor_c && (rep_reg != 32'd0) && (cur_rep == rep_reg - 32'd1);

  always_ff @(posedge clk_in1) begin
    if (beat && !overflow) ram[wr_count[ADDR_WIDTH-1:0]] <= wfin_axis.tdata;
    if (issue) rd_data <= ram[cur_addr];
    if (push) fifo_data[wptr] <= rd_data;
  end

  always_ff @(posedge clk_in1) begin
    if (rst) begin
      state          <= IDLE;
      len_reg        <= '0;
      rep_reg        <= '0;
      wr_count       <= '0;
      wf_len_err     <= 1'b0;
      wf_write_ready <= 1'b0;
      wf_read_ready  <= 1'b0;
      in_ready       <= 1'b0;
    end else begin
      state          <= next_state;
      wf_write_ready <= (next_state == IDLE) || (next_state == ARMED);
      wf_read_ready  <= (next_state == ARMED);
      in_ready       <= (next_state == WRITE);
      if (init_seen) begin
        if (len_bad) begin
          wf_len_err <= 1'b1;
        end else begin
          wf_len_err <= 1'b0;
          len_reg    <= LW'(len_in);
          rep_reg    <= rep_in;
          wr_count   <= '0;
        end
      end
      // Beats beyond the requested length are swallowed until tlast and flagged.
      if (beat) begin
        if (overflow) wf_len_err <= 1'b1;
        else          wr_count   <= wr_count + LW'(1);
        if (wfin_axis.tlast && !overflow) len_reg <= wr_count + LW'(1);
      end
    end
  end

  always_ff @(posedge clk_in1) begin
    if (rst) begin
      rd_addr    <= '0;
      play_last  <= '0;
      rep_cnt    <= '0;
      issue_done <= 1'b0;
      rd_valid   <= 1'b0;
      rd_eor     <= 1'b0;
      rd_fin     <= 1'b0;
      fifo_eor   <= '0;
      fifo_fin   <= '0;
      cnt        <= '0;
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      stop_req   <= 1'b0;
      stop_vis   <= 1'b0;
    end else begin
      if (issue) begin
        rd_addr <= eor_c ? '0 : cur_addr + ADDR_WIDTH'(1);
        rep_cnt <= eor_c ? cur_rep + 32'd1 : cur_rep;
        if (fin_c) issue_done <= 1'b1;
      end
      rd_valid <= issue;
      rd_eor   <= eor_c;
      rd_fin   <= fin_c;
      if (done) begin
        cnt  <= '0;
        wptr <= 1'b0;
        rptr <= 1'b0;
      end else begin
        if (push) begin
          fifo_eor[wptr] <= rd_eor;
          fifo_fin[wptr] <= rd_fin;
          wptr           <= ~wptr;
        end
        if (pop) rptr <= ~rptr;
        cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
      // The stop view is frozen while stalled so tlast cannot change under backpressure.
      if (wf_stop && state == PLAY) stop_req <= 1'b1;
      if (!stall) stop_vis <= stop_req;
      if (start) begin
        play_last  <= start_last;
        issue_done <= fin_c;
        stop_req   <= 1'b0;
        stop_vis   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_waveform_playback_buffer.sv
// Scoreboard bench for waveform_playback_buffer: expected beats are queued as
// playback is triggered and popped as the DUT hands words out.
module tb_waveform_playback_buffer;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] params;
  logic         init, trig, stop;
  logic         write_ready, read_ready, len_err;

  waveform_playback_buffer_if #(.DATA_WIDTH(32)) wfin ();
  waveform_playback_buffer_if #(.DATA_WIDTH(32)) wfout ();

  waveform_playback_buffer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .WRITE_BEFORE_READ(1'b1)
  ) dut (
    .clk_in1(clk), .rst(rst), .waveform_parameters(params),
    .init_wf_write(init), .wf_trigger(trig), .wf_stop(stop),
    .wf_write_ready(write_ready), .wf_read_ready(read_ready), .wf_len_err(len_err),
    .wfin_axis(wfin), .wfout_axis(wfout)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic last; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int rdy_mode = 0;
  bit sb_en = 1'b1;
  int cyc = 0, beats = 0, first_cyc = 0, last_cyc = 0;
  bit hold_pending = 1'b0;
  logic [32:0] hold_word;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Monitor: compares every handshake against the queue and checks stability under stall.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (sb_en) begin
      if (hold_pending) begin
        checkOutput("hold_valid", 64'(wfout.tvalid), 64'd1);
        checkOutput("hold_word", 64'({wfout.tlast, wfout.tdata}), 64'(hold_word));
      end
      if (wfout.tvalid && wfout.tready) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_beat", 64'(wfout.tdata), 64'hDEAD_0000_0000);
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat_data", 64'(wfout.tdata), 64'(e.data));
          checkOutput("beat_last", 64'(wfout.tlast), 64'(e.last));
          checkOutput("beat_keep", 64'(wfout.tkeep), 64'hF);
        end
        if (beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
      end
    end
    hold_pending = wfout.tvalid && !wfout.tready;
    hold_word    = {wfout.tlast, wfout.tdata};
  end

  initial begin
    wfout.tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       wfout.tready = 1'b1;
        1:       wfout.tready = ~wfout.tready;
        default: wfout.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic doInit(input int len, input int rep);
    params = {64'd0, 32'(rep), 32'(len)};
    init = 1'b1; tick(); init = 1'b0;
  endtask

  // Streams nwords counter words starting at base, tlast on the final one.
  task automatic applyStimulus(input int nwords, input logic [31:0] base);
    int sent = 0;
    int budget = 0;
    while (sent < nwords && budget < 5000) begin
      wfin.tdata  = base + 32'(sent);
      wfin.tkeep  = 4'($urandom_range(0, 15));
      wfin.tvalid = 1'b1;
      wfin.tlast  = (sent == nwords - 1);
      @(negedge clk);
      if (wfin.tready) sent++;
      budget++;
      tick();
    end
    wfin.tvalid = 1'b0;
    wfin.tlast  = 1'b0;
    if (sent < nwords) checkOutput("capture_timeout", 64'(sent), 64'(nwords));
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin tick(); n++; end
    if (exp_q.size() != 0) begin
      checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic playCheck(input int len, input int reps, input logic [31:0] base,
                           input bit lat_chk, input bit gap_chk);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < len; i++)
        exp_q.push_back('{base + 32'(i), (r == reps - 1) && (i == len - 1)});
    beats = 0;
    trig = 1'b1; tick(); trig = 1'b0;
    if (lat_chk) begin
      @(negedge clk); checkOutput("latency_early", 64'(wfout.tvalid), 64'd0);
      @(negedge clk); checkOutput("latency_first", 64'(wfout.tvalid), 64'd1);
      tick();
    end
    waitDrain(len * reps * 4 + 50);
    if (gap_chk) checkOutput("no_bubble", 64'(last_cyc - first_cyc + 1), 64'(len * reps));
    repeat (3) tick();
    checkOutput("ready_after", 64'({read_ready, wfout.tvalid}), 64'b10);
  endtask

  function automatic logic [63:0] allOutputs();
    return 64'({wfout.tvalid, wfout.tlast, wfout.tkeep, wfout.tdata,
                write_ready, read_ready, len_err, wfin.tready});
  endfunction

  initial begin
    int n;
    rst = 1'b1; params = '0; init = 1'b0; trig = 1'b0; stop = 1'b0;
    wfin.tdata = '0; wfin.tkeep = '0; wfin.tvalid = 1'b0; wfin.tlast = 1'b0;
    repeat (3) tick();
    @(negedge clk); checkOutput("reset_outputs", allOutputs(), 64'd0);
    rst = 1'b0; tick(); tick();
    checkOutput("idle_ready", 64'({write_ready, read_ready}), 64'b10);

    // Trigger with nothing captured must not play.
    trig = 1'b1; tick(); trig = 1'b0;
    repeat (10) tick();
    checkOutput("no_play_empty", 64'({read_ready, wfout.tvalid}), 64'b00);

    doInit(0, 1); tick();
    checkOutput("len_zero", 64'({len_err, wfin.tready, write_ready}), 64'b101);
    doInit(1025, 1); tick();
    checkOutput("len_too_big", 64'({len_err, wfin.tready, write_ready}), 64'b101);

    $display("[TB] length 128, one repetition");
    doInit(128, 1);
    checkOutput("init_clears_err", 64'(len_err), 64'd0);
    applyStimulus(128, 32'd0); tick();
    checkOutput("armed", 64'({read_ready, len_err}), 64'b10);
    playCheck(128, 1, 32'd0, 1'b1, 1'b1);

    $display("[TB] backpressure");
    rdy_mode = 1; playCheck(128, 1, 32'd0, 1'b0, 1'b0);
    rdy_mode = 2; playCheck(128, 1, 32'd0, 1'b0, 1'b0);
    rdy_mode = 0; tick();

    $display("[TB] length 16, three repetitions");
    doInit(16, 3); applyStimulus(16, 32'h100); tick();
    playCheck(16, 3, 32'h100, 1'b0, 1'b1);

    $display("[TB] early tlast and overlong stream");
    doInit(64, 1); applyStimulus(40, 32'h200); tick();
    checkOutput("short_no_err", 64'(len_err), 64'd0);
    playCheck(40, 1, 32'h200, 1'b0, 1'b1);
    doInit(8, 1); applyStimulus(12, 32'h300); tick();
    checkOutput("overlong_err", 64'({len_err, read_ready}), 64'b11);
    playCheck(8, 1, 32'h300, 1'b0, 1'b1);

    $display("[TB] continuous with stop");
    doInit(16, 0); applyStimulus(16, 32'h400); tick();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 16; i++)
        exp_q.push_back('{32'h400 + 32'(i), (r == 1) && (i == 15)});
    beats = 0;
    trig = 1'b1; tick(); trig = 1'b0;
    n = 0;
    while (beats < 21 && n < 200) begin tick(); n++; end
    checkOutput("stop_point", 64'(beats >= 21), 64'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    waitDrain(200);
    repeat (3) tick();
    checkOutput("stop_ready", 64'({read_ready, wfout.tvalid}), 64'b10);

    $display("[TB] reset during playback");
    sb_en = 1'b0;
    trig = 1'b1; tick(); trig = 1'b0;
    repeat (10) tick();
    checkOutput("playing_before_rst", 64'(wfout.tvalid), 64'd1);
    rst = 1'b1; tick();
    @(negedge clk); checkOutput("rst_mid_play", allOutputs(), 64'd0);
    tick(); rst = 1'b0; tick(); tick();
    sb_en = 1'b1;
    trig = 1'b1; tick(); trig = 1'b0;
    repeat (10) tick();
    checkOutput("no_play_after_rst", 64'({write_ready, read_ready, wfout.tvalid}), 64'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end
endmodule
